// File: rtl/softmax_pkg.sv
// Shared constants, state encoding and exp-table generator for the streaming softmax.
package softmax_pkg;

  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 10;
  localparam int ROW_LEN_MAX = 64;
  localparam int LUT_ADDR_W  = 8;
  localparam int EXP_RANGE_W = 3;

  // Controller state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_EXP  = 3'd2;
  localparam state_t ST_DIV  = 3'd3;
  localparam state_t ST_EMIT = 3'd4;

  // Table entry k = round(2^frac_w * exp(-k * step)), step = 2^range_w / 2^addr_w
  function automatic int exp_lut_init(input int k, input int frac_w,
                                      input int addr_w, input int range_w);
    real step;
    real val;
    step = (2.0 ** range_w) / (2.0 ** addr_w);
    val  = (2.0 ** frac_w) * $exp(-real'(k) * step);
    return $rtoi($floor(val + 0.5));
  endfunction

endpackage

// File: rtl/softmax_stream_unit_if.sv
// Row input stream, probability output stream and status for the softmax unit.
interface softmax_stream_unit_if #(
  parameter int DATA_W = softmax_pkg::DATA_W,
  parameter int LEN_W  = $clog2(softmax_pkg::ROW_LEN_MAX + 1)
);
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/softmax_exp_lut.sv
// Registered exp ROM: one lookup per cycle, result one cycle later.
module softmax_exp_lut #(
  parameter int FRAC_W      = softmax_pkg::FRAC_W,
  parameter int LUT_ADDR_W  = softmax_pkg::LUT_ADDR_W,
  parameter int EXP_RANGE_W = softmax_pkg::EXP_RANGE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LUT_ADDR_W-1:0] addr,
  input  logic                  zero,
  output logic [FRAC_W:0]       data
);
  import softmax_pkg::*;

  localparam int DEPTH = 1 << LUT_ADDR_W;

  logic [FRAC_W:0] rom [DEPTH];
  logic [FRAC_W:0] data_d;
  logic [FRAC_W:0] data_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = (FRAC_W + 1)'(exp_lut_init(g, FRAC_W, LUT_ADDR_W, EXP_RANGE_W));
  end

  // Differences beyond the table range underflow to zero
  always_comb begin
    data_d = zero ? '0 : rom[addr];
  end

  // Output register gives the fixed one-cycle lookup latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/softmax_stream_unit.sv
// Streaming softmax: buffer a row, subtract its max, exponentiate, take one
// reciprocal of the sum and stream the normalised row back out.
module softmax_stream_unit #(
  parameter int DATA_W      = softmax_pkg::DATA_W,
  parameter int FRAC_W      = softmax_pkg::FRAC_W,
  parameter int ROW_LEN_MAX = softmax_pkg::ROW_LEN_MAX,
  parameter int LUT_ADDR_W  = softmax_pkg::LUT_ADDR_W,
  parameter int EXP_RANGE_W = softmax_pkg::EXP_RANGE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_stream_unit_if.slave bus
);
  import softmax_pkg::*;

  localparam int LEN_W  = $clog2(ROW_LEN_MAX + 1);
  localparam int IDX_W  = $clog2(ROW_LEN_MAX);
  localparam int SUM_W  = FRAC_W + 1 + $clog2(ROW_LEN_MAX);
  localparam int REM_W  = SUM_W + 1;
  localparam int EXP_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * EXP_W + 1;
  localparam int DIFF_W = DATA_W + 1;
  localparam int SHIFT  = FRAC_W + EXP_RANGE_W - LUT_ADDR_W;
  localparam int DIVC_W = $clog2(FRAC_W + 1);

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [EXP_W-1:0]         recip_q, recip_d;
  logic [DIVC_W-1:0]        div_cnt_q, div_cnt_d;
  logic                     lut_vld_q, lut_vld_d;
  logic [IDX_W-1:0]         wb_idx_q, wb_idx_d;

  logic [DATA_W-1:0]        row_mem_q [ROW_LEN_MAX];
  logic                     row_we;
  logic [IDX_W-1:0]         row_waddr;
  logic [DATA_W-1:0]        row_wdata;
  logic [IDX_W-1:0]         row_raddr;
  logic [DATA_W-1:0]        row_rdata;

  logic                     in_fire;
  logic                     out_fire;
  logic                     emit_last;
  logic [LEN_W-1:0]         len_in;
  logic [DIFF_W-1:0]        neg_diff;
  logic [LUT_ADDR_W-1:0]    lut_addr;
  logic                     lut_zero;
  logic [EXP_W-1:0]         lut_data;
  logic [REM_W-1:0]         rem_shift;
  logic [PROD_W-1:0]        prod;
  logic [PROD_W-1:0]        rounded;
  logic [DATA_W-1:0]        prob;

  assign row_rdata = row_mem_q[row_raddr];
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign emit_last = (idx_q == len_q - LEN_W'(1));

  // Row length: zero or anything beyond the buffer depth selects a full-size row
  always_comb begin
    if (bus.cfg_len == '0 || bus.cfg_len > LEN_W'(ROW_LEN_MAX)) len_in = LEN_W'(ROW_LEN_MAX);
    else                                                        len_in = bus.cfg_len;
  end

  // Distance below the row max and the matching exp table address
  always_comb begin
    neg_diff = {max_q[DATA_W-1], max_q} - {row_rdata[DATA_W-1], row_rdata};
    lut_addr = LUT_ADDR_W'(neg_diff >> SHIFT);
    lut_zero = (neg_diff >> (FRAC_W + EXP_RANGE_W)) != '0;
  end

  softmax_exp_lut #(
    .FRAC_W      (FRAC_W),
    .LUT_ADDR_W  (LUT_ADDR_W),
    .EXP_RANGE_W (EXP_RANGE_W)
  ) u_exp_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (lut_addr),
    .zero  (lut_zero),
    .data  (lut_data)
  );

  // Normalised output: exp * recip rounded to FRAC_W fraction bits, capped at 1.0
  always_comb begin
    prod    = PROD_W'(row_rdata[EXP_W-1:0]) * PROD_W'(recip_q);
    rounded = (prod + (PROD_W'(1) << (FRAC_W - 1))) >> FRAC_W;
    if (rounded > (PROD_W'(1) << FRAC_W)) prob = DATA_W'(1) << FRAC_W;
    else                                  prob = DATA_W'(rounded);
  end

  // Row sequencing: load, exponentiate, divide, emit
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    max_d     = max_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    recip_d   = recip_q;
    div_cnt_d = div_cnt_q;
    lut_vld_d = 1'b0;
    wb_idx_d  = wb_idx_q;
    row_we    = 1'b0;
    row_waddr = idx_q[IDX_W-1:0];
    row_wdata = bus.in_data;
    row_raddr = idx_q[IDX_W-1:0];
    rem_shift = rem_q << 1;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          len_d     = len_in;
          row_we    = 1'b1;
          row_waddr = '0;
          max_d     = $signed(bus.in_data);
          sum_d     = '0;
          if (len_in == LEN_W'(1)) begin
            state_d = ST_EXP;
            idx_d   = '0;
          end else begin
            state_d = ST_LOAD;
            idx_d   = LEN_W'(1);
          end
        end
      end

      ST_LOAD: begin
        if (in_fire) begin
          row_we = 1'b1;
          if ($signed(bus.in_data) > max_q) max_d = $signed(bus.in_data);
          if (emit_last) begin
            state_d = ST_EXP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      ST_EXP: begin
        if (lut_vld_q) begin
          row_we    = 1'b1;
          row_waddr = wb_idx_q;
          row_wdata = DATA_W'(lut_data);
          sum_d     = sum_q + SUM_W'(lut_data);
        end
        if (idx_q == len_q) begin
          state_d   = ST_DIV;
          rem_d     = REM_W'(1) << (FRAC_W - 1);
          recip_d   = '0;
          div_cnt_d = '0;
        end else begin
          lut_vld_d = 1'b1;
          wb_idx_d  = idx_q[IDX_W-1:0];
          idx_d     = idx_q + LEN_W'(1);
        end
      end

      ST_DIV: begin
        if (rem_shift >= {1'b0, sum_q}) begin
          rem_d   = rem_shift - {1'b0, sum_q};
          recip_d = {recip_q[EXP_W-2:0], 1'b1};
        end else begin
          rem_d   = rem_shift;
          recip_d = {recip_q[EXP_W-2:0], 1'b0};
        end
        if (div_cnt_q == DIVC_W'(FRAC_W)) begin
          state_d = ST_EMIT;
          idx_d   = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIVC_W'(1);
        end
      end

      ST_EMIT: begin
        if (out_fire) begin
          if (emit_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers; reset discards any partial row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      recip_q   <= '0;
      div_cnt_q <= '0;
      lut_vld_q <= 1'b0;
      wb_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      recip_q   <= recip_d;
      div_cnt_q <= div_cnt_d;
      lut_vld_q <= lut_vld_d;
      wb_idx_q  <= wb_idx_d;
    end
  end

  // Row buffer holds raw scores, then exp values once EXP has passed them
  always_ff @(posedge clk) begin
    if (row_we) row_mem_q[row_waddr] <= row_wdata;
  end

  assign bus.in_ready  = rst_n && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out_last  = (state_q == ST_EMIT) && emit_last;
  assign bus.out_data  = (state_q == ST_EMIT) ? prob : '0;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_softmax_stream_unit.sv
// Directed bench for softmax_stream_unit with a behavioural softmax model.
module tb_softmax_stream_unit;

  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 10;
  localparam int ROW_LEN_MAX = 64;
  localparam int LEN_W       = 7;
  localparam int ONE         = 1 << FRAC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  softmax_stream_unit_if bus ();

  softmax_stream_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp_data_q[$];
  bit exp_last_q[$];
  bit first_pending = 1'b0;
  int exp_first_cyc = 0;
  bit stalled = 1'b0;
  int held_data = 0;
  int held_last = 0;

  int row_vals[ROW_LEN_MAX];
  int model_out[ROW_LEN_MAX];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // exp(diff) in Q.FRAC_W as the table defines it: step 1/32, zero below -8.0
  function automatic int lut_exp(input int neg_diff);
    int  k;
    real r;
    if (neg_diff >= (1 << (FRAC_W + 3))) return 0;
    k = neg_diff / (1 << (FRAC_W + 3 - 8));
    r = real'(ONE) * $exp(-real'(k) * 8.0 / 256.0);
    return $rtoi($floor(r + 0.5));
  endfunction

  // Softmax of row_vals[0..n-1] into model_out
  task automatic computeModel(input int n);
    int mx;
    int s;
    int recip;
    int v;
    mx = row_vals[0];
    for (int i = 1; i < n; i++) if (row_vals[i] > mx) mx = row_vals[i];
    s = 0;
    for (int i = 0; i < n; i++) s += lut_exp(mx - row_vals[i]);
    recip = (1 << (2 * FRAC_W)) / s;
    for (int i = 0; i < n; i++) begin
      v = (lut_exp(mx - row_vals[i]) * recip + (ONE / 2)) >> FRAC_W;
      if (v > ONE) v = ONE;
      model_out[i] = v;
    end
  endtask

  // Send one row; optionally queue its expected output and change cfg_len mid-row
  task automatic applyStimulus(input int cfg, input int n, input bit push, input bit chg_cfg);
    int hs_cyc;
    int guard;
    bit rdy;
    hs_cyc = 0;
    computeModel(n);
    if (push) begin
      for (int i = 0; i < n; i++) begin
        exp_data_q.push_back(model_out[i]);
        exp_last_q.push_back(i == n - 1);
      end
    end
    bus.cfg_len = LEN_W'(cfg);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(row_vals[i]);
      guard = 0;
      rdy   = 1'b0;
      while (!rdy && guard < 300) begin
        @(negedge clk);
        rdy    = bus.in_ready;
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!rdy) checkOutput("in_ready_timeout", 0, 1);
      if (chg_cfg && i == 0) bus.cfg_len = LEN_W'(2);
    end
    bus.in_valid = 1'b0;
    if (push) begin
      first_pending = 1'b1;
      exp_first_cyc = hs_cyc + 1 + n + 1 + FRAC_W + 1;
    end
  endtask

  // Wait for the queued row to drain, then confirm the unit is idle and ready
  task automatic waitRowDone();
    int guard;
    guard = 0;
    while (exp_data_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (exp_data_q.size() != 0) begin
      checkOutput("row_done_timeout", exp_data_q.size(), 0);
      exp_data_q.delete();
      exp_last_q.delete();
    end
    @(posedge clk);
    #1;
    checkOutput("idle_in_ready", bus.in_ready, 1);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_out_valid", bus.out_valid, 0);
  endtask

  // Output monitor: every valid beat is compared with the model queue
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else if (bus.out_valid) begin
      if (first_pending) begin
        checkOutput("first_out_latency", cyc, exp_first_cyc);
        first_pending = 1'b0;
      end
      if (stalled) begin
        checkOutput("stall_data_hold", bus.out_data, held_data);
        checkOutput("stall_last_hold", bus.out_last, held_last);
      end
      if (exp_data_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        checkOutput("out_data", bus.out_data, exp_data_q[0]);
        checkOutput("out_last", bus.out_last, exp_last_q[0]);
        if (bus.out_ready) begin
          void'(exp_data_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      stalled   = !bus.out_ready;
      held_data = bus.out_data;
      held_last = bus.out_last;
    end else begin
      if (stalled) checkOutput("valid_dropped_while_stalled", 0, 1);
      stalled = 1'b0;
      checkOutput("out_last_without_valid", bus.out_last, 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit [7:0] pat;
    int guard;

    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    #2;
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    // 1: four zeros -> uniform 256
    $display("[TB] row: len=4 zeros");
    for (int i = 0; i < 4; i++) row_vals[i] = 0;
    applyStimulus(4, 4, 1'b1, 1'b0);
    checkOutput("model_zeros_0", model_out[0], 256);
    checkOutput("model_zeros_3", model_out[3], 256);
    waitRowDone();

    // 2: single element -> 1.0
    $display("[TB] row: len=1");
    row_vals[0] = 5120;
    applyStimulus(1, 1, 1'b1, 1'b0);
    checkOutput("model_single", model_out[0], 1024);
    waitRowDone();

    // 3: difference beyond the table range -> zero
    $display("[TB] row: len=2 clamp");
    row_vals[0] = 3072;
    row_vals[1] = -20480;
    applyStimulus(2, 2, 1'b1, 1'b0);
    checkOutput("model_clamp_0", model_out[0], 1024);
    checkOutput("model_clamp_1", model_out[1], 0);
    waitRowDone();

    // 4: sixteen elements at +31.0
    $display("[TB] row: len=16 large");
    for (int i = 0; i < 16; i++) row_vals[i] = 31744;
    applyStimulus(16, 16, 1'b1, 1'b0);
    checkOutput("model_large", model_out[5], 64);
    waitRowDone();

    // 5: backpressure with ready pattern 1,0,0,1,0,1,1,1
    $display("[TB] row: backpressure");
    row_vals[0] = 1024;
    row_vals[1] = 0;
    row_vals[2] = 1024;
    row_vals[3] = 0;
    applyStimulus(4, 4, 1'b1, 1'b0);
    checkOutput("model_bp_hi", model_out[0], 374);
    checkOutput("model_bp_lo", model_out[1], 138);
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("bp_out_valid_seen", bus.out_valid, 1);
    pat = 8'b1110_1001;
    for (int p = 0; p < 8; p++) begin
      bus.out_ready = pat[p];
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    waitRowDone();

    // 6: cfg_len change mid-row and in_valid during EXP are ignored
    $display("[TB] row: cfg change and ignored input");
    row_vals[0] = -2048;
    row_vals[1] = 512;
    row_vals[2] = 0;
    row_vals[3] = 7000;
    row_vals[4] = -300;
    applyStimulus(5, 5, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7FFF;
    for (int c = 0; c < 4; c++) begin
      checkOutput("exp_in_ready_low", bus.in_ready, 0);
      checkOutput("exp_busy", bus.busy, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    waitRowDone();

    // 7: cfg_len = 0 selects a full-length ramp row
    $display("[TB] row: len=0 full ramp");
    for (int i = 0; i < ROW_LEN_MAX; i++) row_vals[i] = i * 200 - 6000;
    applyStimulus(0, ROW_LEN_MAX, 1'b1, 1'b0);
    waitRowDone();

    // 8: reset during EXP drops the row
    $display("[TB] row: reset mid-row");
    for (int i = 0; i < 4; i++) row_vals[i] = 0;
    applyStimulus(4, 4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    checkOutput("mid_rst_release_ready", bus.in_ready, 1);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("mid_rst_nothing_emitted", bus.busy, 0);

    // 9: clean row after the aborted one
    $display("[TB] row: len=4 zeros after reset");
    applyStimulus(4, 4, 1'b1, 1'b0);
    waitRowDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
